mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 56 +++++
 rtl/mult_div_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // MULT/MULTU/DIV/DIVU all have op[2] clear; they are the multi-cycle ops.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for the latched MDU op and operands.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic        b_zero;
  logic        s_ovf;
  logic [31:0] div_s_b;
  logic [31:0] div_u_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign b_zero = (b == 32'd0);
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Divisors are forced to 1 in the special cases so the dividers never see
  // a zero or an overflowing operand pair; those results are overridden below.
  assign div_s_b = (b_zero || s_ovf) ? 32'd1 : b;
  assign div_u_b = b_zero ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quo_s  = $signed(a) / $signed(div_s_b);
  assign rem_s  = $signed(a) % $signed(div_s_b);
  assign quo_u  = a / div_u_b;
  assign rem_u  = a % div_u_b;

  // Select the result for the latched op, applying divide special cases.
  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        if (b_zero)     result = {a, 32'hFFFF_FFFF};
        else if (s_ovf) result = {32'd0, 32'h8000_0000};
        else            result = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (b_zero) result = {a, 32'hFFFF_FFFF};
        else        result = {rem_u, quo_u};
      end
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit with a fixed-latency busy window.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | accepts MULT/DIV (go RUN) or MTHI/MTLO (write hi/lo directly)
// ST_RUN  | counting down latency; hi/lo written when count hits 1
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mdu_stall
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      arith_result;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (arith_result)
  );

  // State, counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: issue in IDLE, down-count in RUN, write result at terminal count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith_op(mdu_op)) begin
            op_d    = mdu_op;
            a_d     = src_a;
            b_d     = src_b;
            count_d = mdu_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state_d = ST_RUN;
          end else if (mdu_op == OP_MTHI) begin
            hi_d = src_a;
          end else if (mdu_op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_RUN: begin
        count_d = count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          {hi_d, lo_d} = arith_result;
          count_d      = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mdu_stall = busy | (start & is_arith_op(mdu_op));

endmodule
